// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit between the execute ALU and a single-port data memory (req/ack).
// Defining MISALIGN_TRAP_EN makes misaligned half/word accesses trap instead of masking the low address bits.
module lsu_mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo;
  logic             req_ok;
  logic             trap;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Decode the incoming request: legality, trap, byte lanes and replicated store data.
  always_comb begin
    if (is_store) req_ok = !funct3[2] && (funct3[1:0] != 2'b11);
    else          req_ok = (funct3[1:0] != 2'b11) && (funct3 != 3'b110);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = req_ok && (((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
`endif
    case (funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << {addr[1], 1'b0};
        wdata_nxt = {2{wdata[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata;
      end
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

`ifndef MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

  // Illegal or trapped requests skip REQ entirely so the memory never sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo    <= 2'b00;
      rdata      <= '0;
      err        <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign   <= 1'b0;
`endif
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            addr_lo    <= addr[1:0];
            mem_addr   <= {addr[31:2], 2'b00};
            mem_be     <= be_nxt;
            mem_wdata  <= wdata_nxt;
            mem_we     <= is_store && req_ok && !trap;
            rdata      <= '0;
            err        <= !req_ok;
`ifdef MISALIGN_TRAP_EN
            misalign   <= trap;
`endif
            if (req_ok && !trap) begin
              mem_req <= 1'b1;
              state   <= S_REQ;
            end else begin
              state   <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!is_store_q) rdata <= ld_data;
            state   <= S_DONE;
          end else if ((TIMEOUT != 0) && (cnt + 1'b1 == TIMEOUT_C)) begin
            err     <= 1'b1;
            mem_req <= 1'b0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and random transactions checked against an arithmetic reference model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_mem_stage;

  localparam int TB_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_mem_stage #(.TIMEOUT(TB_TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .err(err), .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the RV32I rules using plain arithmetic.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] word,
                                output logic acc, output logic [3:0] be, output logic [31:0] mwd,
                                output logic [31:0] rd, output logic er, output logic mis);
    int size;
    logic valid, trap_en, misal;
    logic [31:0] v;
    size = int'(f3) % 4;
    if (st) valid = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    valid = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef MISALIGN_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    misal = ((size == 1) && (a % 2 != 0)) || ((size == 2) && (a % 4 != 0));
    er  = !valid;
    mis = valid && trap_en && misal;
    acc = valid && !mis;
    rd  = 32'd0;
    if (size == 0) begin
      be  = 4'(1 << (a % 4));
      mwd = (wd & 32'hFF) * 32'h01010101;
      v   = (word >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end else if (size == 1) begin
      be  = 4'(3 << (2 * ((a / 2) % 2)));
      mwd = (wd & 32'hFFFF) * 32'h00010001;
      v   = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end else begin
      be  = 4'hF;
      mwd = wd;
      v   = word;
    end
    if (!st) rd = v;
  endfunction

  // One full transaction; ack_delay outside 0..TB_TIMEOUT-1 means the memory never answers.
  task automatic apply_stimulus(input string name, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                                input int ack_delay, input bit poke_start);
    logic acc, er, mis;
    logic [3:0] be;
    logic [31:0] mwd, rd, exp_rd;
    logic exp_er;
    int n;
    bit got;
    model(st, f3, a, wd, word, acc, be, mwd, rd, er, mis);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0;
    check_output({name, " busy"}, busy, 1);
    n = 0;
    got = 0;
    if (acc) begin
      check_output({name, " mem_addr"}, mem_addr, a & ~32'h3);
      check_output({name, " mem_be"}, mem_be, be);
      check_output({name, " mem_we"}, mem_we, st);
      if (st) check_output({name, " mem_wdata"}, mem_wdata, mwd);
      while (!got && n < TB_TIMEOUT) begin
        check_output({name, " mem_req held"}, mem_req, 1);
        check_output({name, " no early done"}, done, 0);
        if (n == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = word; got = 1;
        end else begin
          mem_rdata = $urandom;
        end
        if (poke_start) begin
          start = 1'b1; is_store = 1'($urandom_range(0, 1));
          funct3 = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; start = 1'b0;
        n++;
      end
    end
    check_output({name, " mem_req low"}, mem_req, 0);
    exp_er = er || (acc && !got);
    exp_rd = (acc && got) ? rd : 32'd0;
    check_output({name, " done"}, done, 1);
    check_output({name, " busy in done"}, busy, 1);
    check_output({name, " err"}, err, exp_er);
    check_output({name, " misalign"}, misalign, mis);
    check_output({name, " rdata"}, rdata, exp_rd);
    @(posedge clk); #1;
    check_output({name, " done pulse"}, done, 0);
    check_output({name, " idle busy"}, busy, 0);
    check_output({name, " rdata held"}, rdata, exp_rd);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset rdata", rdata, 0);
    check_output("reset err", err, 0);
    check_output("reset misalign", misalign, 0);
    check_output("reset mem_req", mem_req, 0);
    check_output("reset mem_we", mem_we, 0);
    check_output("reset mem_addr", mem_addr, 0);
    check_output("reset mem_be", mem_be, 0);
    check_output("reset mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    apply_stimulus("LW", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    apply_stimulus("LB", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b0);
    apply_stimulus("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
    apply_stimulus("LH", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017F00, 2, 1'b0);
    apply_stimulus("LHU", 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234FEDC, 0, 1'b0);
    apply_stimulus("SH", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 1'b0);
    apply_stimulus("SB", 1'b1, 3'b000, 32'h301, 32'hCAFE005A, 32'h0, 0, 1'b0);
    apply_stimulus("SW", 1'b1, 3'b010, 32'h304, 32'h87654321, 32'h0, 1, 1'b0);
    apply_stimulus("LW timeout", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, -1, 1'b1);
    apply_stimulus("LD011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0);
    apply_stimulus("ST100", 1'b1, 3'b100, 32'h100, 32'h5, 32'h0, 0, 1'b0);
    apply_stimulus("LW misal", 1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 1'b0);
    apply_stimulus("SH misal", 1'b1, 3'b001, 32'h203, 32'h0000BEEF, 32'h0, 0, 1'b0);

    // Reset in the middle of a request must kill it without a done pulse.
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("rst mid-REQ req before", mem_req, 1);
    rst = 1'b1;
    #1;
    check_output("rst mid-REQ mem_req", mem_req, 0);
    check_output("rst mid-REQ busy", busy, 0);
    check_output("rst mid-REQ done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("rst no done", done, 0);
      check_output("rst stays idle", busy, 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic st;
      logic [2:0] f3;
      int dly;
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      else f3 = 3'($urandom_range(0, 7));
      if (!st && f3 == 3'd3) f3 = 3'd4;
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      apply_stimulus("random", st, f3, $urandom, $urandom, $urandom, dly, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, plus rs2 data and funct3 from decode.
- Drives a single-port data memory over a req/ack handshake and returns sign- or zero-extended load data for writeback.
- Multi-cycle: the core stalls while busy is high.

Parameters:
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before aborting; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I load/store width/sign code.
- addr  in  32  effective address (ALU result).
- wdata  in  32  store data (rs2).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; held until next accepted start.
- err  out  1  abort flag (bad funct3 or timeout); valid with done, held like rdata.
- misalign  out  1  misaligned-access flag; valid with done, held like rdata.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accept/complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  memory read word.

Behaviour:
- Reset (async): state=IDLE; every output 0; timeout counter 0. Reset mid-transaction drops mem_req immediately. No done is issued for the aborted operation.
- FSM states IDLE, REQ, DONE.
- IDLE:
  - On start=1, latch is_store, funct3, addr, wdata and compute mem_be/mem_wdata.
  - Clear err, misalign and rdata.
  - Next state is REQ, or DONE if the request is invalid or trapped.
  - start is ignored in every other state.
- REQ:
  - mem_req=1, busy=1; mem_* outputs stay stable.
  - On mem_ack: if load, rdata <= extract(mem_rdata); go to DONE.
  - Counter increments each REQ cycle without ack. If TIMEOUT≠0 and the counter reaches TIMEOUT: err=1, mem_req drops, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE; counter cleared.
- Minimum latency: start at cycle 0, mem_req in cycle 1, ack in cycle 1 gives done in cycle 2.
- busy is low in IDLE. In the done cycle, busy=1 and start is not yet accepted.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads: same masks, mem_we=0.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extract:
  - Byte/half is selected by the latched addr[1:0]/addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Invalid funct3 (load 011/110/111; store with funct3[2]=1 or 011): no memory access; DONE with err=1.
- Stores leave rdata=0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0: no memory access.
  - Go IDLE→DONE with misalign=1, err=0.
- Undefined:
  - Low address bits are silently ignored: half aligns to addr[1], word to lane 0.
  - The access proceeds normally; misalign is tied 0.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ack on first REQ cycle -> mem_addr=0x100, mem_be=1111, done at cycle 2, rdata=0xDEADBEEF.
- LB addr=0x103 / LBU addr=0x103, mem_rdata=0x80FF0000 -> mem_be=1000; rdata=0xFFFFFF80 / 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, ack delayed 3 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_req held 4 cycles, one done pulse.
- TIMEOUT=16, LW with no ack -> mem_req drops after 16 REQ cycles, done with err=1; start asserted while busy is ignored.
- funct3=011 load -> no mem_req, done in the cycle after start, err=1. Also: rst asserted mid-REQ -> mem_req/busy low immediately, no done.
- LW addr=0x101 -> with MISALIGN_TRAP_EN: no mem_req, done with misalign=1. Without: mem_addr=0x100, mem_be=1111, misalign=0.
